// File: rtl/mul_feed_2239_pkg.sv
// -----------------------------------------------------------------------------
// mul_feed_2239_pkg
//
// Purpose : Constants and helper functions for the mod-2239 multiply feed and
//           the Barrett reducer that consumes its products.
//
// Contents:
//   Q_MOD       modulus (2239)
//   OP_W        operand width (12 bits, covers raw inputs up to 4095)
//   PROD_W      product width (23 bits, covers (Q-1)^2 = 5008644)
//   DEPTH_DEF   default depth of the output FIFO
//   reduce_once single conditional subtraction of q
//   out_of_range operand >= q detect
// -----------------------------------------------------------------------------
package mul_feed_2239_pkg;

    localparam int Q_MOD     = 2239;
    localparam int OP_W      = 12;
    localparam int PROD_W    = 23;
    localparam int DEPTH_DEF = 4;

    // One subtraction is enough: the largest 12-bit value minus q is already
    // below q (4095 - 2239 = 1856).
    function automatic logic [OP_W-1:0] reduce_once(
        input logic [OP_W-1:0] x,
        input logic [OP_W-1:0] q
    );
        return (x >= q) ? (x - q) : x;
    endfunction

    function automatic logic out_of_range(
        input logic [OP_W-1:0] x,
        input logic [OP_W-1:0] q
    );
        return (x >= q);
    endfunction

endpackage

// File: rtl/mul_feed_2239_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Purpose : Single-clock FIFO with synchronous active-high reset. DEPTH must
//           be a power of two so the pointers wrap naturally.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-high (clears pointers and count)
//   push   in   write din this edge (accepted when not full, or when popping)
//   pop    in   remove head this edge (ignored when empty)
//   din    in   write data
//   dout   out  head entry (valid while !empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  current occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_feed_2239.sv
// -----------------------------------------------------------------------------
// mul_feed_2239
//
// Purpose : Two-stage multiply feed for the mod-2239 Barrett reducer.
//           Stage 1 folds each operand into [0, Q) with one subtraction,
//           stage 2 forms the full 23-bit product, and an output FIFO
//           decouples the downstream consumer. The pipeline never stalls;
//           admission is governed by credits so every in-flight product is
//           guaranteed a FIFO slot.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   operand pair present
//   in_ready   out  pair accepted this cycle (registered-state only)
//   in_a       in   operand A, 12-bit unsigned
//   in_b       in   operand B, 12-bit unsigned
//   out_valid  out  dout_p holds a product (FIFO not empty)
//   out_ready  in   downstream consumes dout_p
//   dout_p     out  product < Q*Q, FIFO head
//   err_range  out  sticky: an operand >= Q was accepted
//   err_clr    in   clears err_range (an overlapping set wins)
// -----------------------------------------------------------------------------
module mul_feed_2239
    import mul_feed_2239_pkg::*;
#(
    parameter int Q     = Q_MOD,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] dout_p,
    output logic              err_range,
    input  logic              err_clr
);

    localparam int              CW  = $clog2(DEPTH) + 1;
    localparam logic [OP_W-1:0] Q_L = OP_W'(Q);

    logic              accept;
    logic              range_hit;

    logic              s1_valid;
    logic [OP_W-1:0]   s1_a;
    logic [OP_W-1:0]   s1_b;

    logic              s2_valid;
    logic [PROD_W-1:0] s2_p;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_sum;

    // Everything admitted but not yet popped holds a credit. Built only from
    // registers, so in_ready has no path from in_valid or out_ready. The
    // full term is implied by the sum but keeps the FIFO flag meaningful.
    assign credit_sum = {1'b0, fifo_count}
                      + (CW+1)'(s1_valid)
                      + (CW+1)'(s2_valid);
    assign in_ready   = !fifo_full && (credit_sum < (CW+1)'(DEPTH));

    assign accept    = in_valid && in_ready;
    assign range_hit = accept && (out_of_range(in_a, Q_L) || out_of_range(in_b, Q_L));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            err_range <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;

            if (range_hit) begin
                err_range <= 1'b1;
            end else if (err_clr) begin
                err_range <= 1'b0;
            end
        end
    end

    // Data registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a <= reduce_once(in_a, Q_L);
            s1_b <= reduce_once(in_b, Q_L);
        end
        if (s1_valid) begin
            // Both operands are below Q, so the product fits in PROD_W bits.
            s2_p <= PROD_W'(s1_a) * PROD_W'(s1_b);
        end
    end

    sync_fifo #(
        .WIDTH (PROD_W),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .pop   (out_ready),
        .din   (s2_p),
        .dout  (dout_p),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;

endmodule
